hsid_mse: RTL

Pipelined squared-error accumulator for the hyperspectral identification datapath. It sits directly downstream of the main control FSM, which streams paired band packs from the captured-pixel FIFO and the reference-library FIFO with start, last and valid tags. For each library reference it outputs the sum of squared band differences, tagged with the reference index, to the MSE comparator. Every reference in a run has the same band count, so the undivided sum ranks references the same way as the mean.

---
 rtl/hsid_mse.sv | 110 +++++++++++
 1 files changed

// File: rtl/hsid_mse.sv
// hsid_mse: five-stage squared-error accumulator; emits one sum of squared band
// differences per library reference, tagged with its index.
module hsid_mse #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 9,
  parameter int HSP_LIBRARY_WIDTH = 8
)(
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          clear,
  input  logic [HSP_BANDS_WIDTH-1:0]                    hsp_bands,
  input  logic                                          band_pack_valid,
  input  logic                                          band_pack_start,
  input  logic                                          band_pack_last,
  input  logic [WORD_WIDTH-1:0]                         captured_word,
  input  logic [WORD_WIDTH-1:0]                         ref_word,
  input  logic [HSP_LIBRARY_WIDTH-1:0]                  hsp_ref_count,
  input  logic                                          hsp_ref_last,
  output logic [2*(WORD_WIDTH/2)+HSP_BANDS_WIDTH-1:0]   mse_value,
  output logic [HSP_LIBRARY_WIDTH-1:0]                  mse_ref,
  output logic                                          mse_valid,
  output logic                                          mse_last,
  output logic                                          busy
);
  localparam int EW = WORD_WIDTH/2;
  localparam int MW = 2*EW+HSP_BANDS_WIDTH;
  logic w_flush, w_odd;
  logic signed [EW:0] w_dlo, w_dhi;
  logic [EW-1:0] w_alo, w_ahi;
  logic [2*EW-1:0] w_sqlo, w_sqhi;
  logic [MW-1:0] w_acc_next;
  logic r_s1_v, r_s1_start, r_s1_last, r_s1_rlast;
  logic r_s2_v, r_s2_start, r_s2_last, r_s2_rlast;
  logic r_s3_v, r_s3_start, r_s3_last, r_s3_rlast;
  logic r_s4_v, r_s4_last, r_s4_rlast, r_fresh;
  logic [HSP_LIBRARY_WIDTH-1:0] r_s1_ref, r_s2_ref, r_s3_ref, r_s4_ref;
  logic signed [EW:0] r_s1_dlo, r_s1_dhi;
  logic [2*EW-1:0] r_s2_sqlo, r_s2_sqhi;
  logic [2*EW:0] r_s3_pair;
  logic [MW-1:0] r_acc, r_mse_value;
  logic [HSP_LIBRARY_WIDTH-1:0] r_mse_ref;
  logic r_mse_valid, r_mse_last;
  assign w_flush = ~rst_n | clear;
  // bit 0 alone decides oddness; the reduction only confirms a nonzero count
  assign w_odd   = hsp_bands[0] & (|hsp_bands);
  assign w_dlo   = {1'b0, captured_word[EW-1:0]} - {1'b0, ref_word[EW-1:0]};
  assign w_dhi   = {1'b0, captured_word[WORD_WIDTH-1:EW]} - {1'b0, ref_word[WORD_WIDTH-1:EW]};
  // |d| always fits EW bits since the difference never reaches -2^EW
  assign w_alo   = r_s1_dlo[EW] ? -r_s1_dlo[EW-1:0] : r_s1_dlo[EW-1:0];
  assign w_ahi   = r_s1_dhi[EW] ? -r_s1_dhi[EW-1:0] : r_s1_dhi[EW-1:0];
  assign w_sqlo  = {{EW{1'b0}}, w_alo} * {{EW{1'b0}}, w_alo};
  assign w_sqhi  = {{EW{1'b0}}, w_ahi} * {{EW{1'b0}}, w_ahi};
  assign w_acc_next = ((r_s3_start | r_fresh) ? '0 : r_acc) + {{(HSP_BANDS_WIDTH-1){1'b0}}, r_s3_pair};
  always_ff @(posedge clk) begin
    r_s1_start <= band_pack_start;
    r_s1_last  <= band_pack_last;
    r_s1_rlast <= hsp_ref_last;
    r_s1_ref   <= hsp_ref_count;
    r_s1_dlo   <= w_dlo;
    r_s1_dhi   <= (band_pack_last & w_odd) ? '0 : w_dhi;
    r_s2_start <= r_s1_start;
    r_s2_last  <= r_s1_last;
    r_s2_rlast <= r_s1_rlast;
    r_s2_ref   <= r_s1_ref;
    r_s2_sqlo  <= w_sqlo;
    r_s2_sqhi  <= w_sqhi;
    r_s3_start <= r_s2_start;
    r_s3_last  <= r_s2_last;
    r_s3_rlast <= r_s2_rlast;
    r_s3_ref   <= r_s2_ref;
    r_s3_pair  <= {1'b0, r_s2_sqlo} + {1'b0, r_s2_sqhi};
    r_s4_last  <= r_s3_last;
    r_s4_rlast <= r_s3_rlast;
    r_s4_ref   <= r_s3_ref;
  end
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s3_v      <= 1'b0;
      r_s4_v      <= 1'b0;
      r_acc       <= '0;
      r_fresh     <= 1'b1;
      r_mse_value <= '0;
      r_mse_ref   <= '0;
      r_mse_valid <= 1'b0;
      r_mse_last  <= 1'b0;
    end else begin
      r_s1_v      <= band_pack_valid;
      r_s2_v      <= r_s1_v;
      r_s3_v      <= r_s2_v;
      r_s4_v      <= r_s3_v;
      r_mse_valid <= r_s4_v & r_s4_last;
      if (r_s3_v) begin
        r_acc   <= w_acc_next;
        r_fresh <= r_s3_last;
      end
      if (r_s4_v & r_s4_last) begin
        r_mse_value <= r_acc;
        r_mse_ref   <= r_s4_ref;
        r_mse_last  <= r_s4_rlast;
      end
    end
  end
  assign mse_value = r_mse_value;
  assign mse_ref   = r_mse_ref;
  assign mse_valid = r_mse_valid;
  assign mse_last  = r_mse_last;
  assign busy      = r_s1_v | r_s2_v | r_s3_v | r_s4_v | r_mse_valid;
endmodule
